// File: rtl/logit_frame_feeder.sv
// ---------------------------------------------------------------------------
// logit_frame_feeder : serial fp16 logit collector and sequencer for the
//                      10-way argmax engine.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module logit_frame_feeder #(
  parameter int N_LOGITS   = 10,
  parameter int WIDTH      = 16,
  parameter int ARGMAX_LAT = 28,
  parameter int REARM_CYC  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_last,
  output logic [N_LOGITS*WIDTH-1:0] logits_o,
  output logic                      am_rst_n,
  output logic                      am_start,
  input  logic [3:0]                am_count,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [3:0]                res_class,
  output logic                      res_err
);

  localparam int IW  = 4;
  localparam int RCW = $clog2(REARM_CYC + 1);
  localparam int WCW = 6;

  localparam logic [2:0] S_FILL   = 3'd0;
  localparam logic [2:0] S_REARM  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [RCW-1:0]            rearm_q, rearm_d;
  logic [WCW-1:0]            wait_q, wait_d;
  logic [N_LOGITS*WIDTH-1:0] logits_q, logits_d;
  logic                      am_rst_n_q, am_rst_n_d;
  logic                      am_start_q, am_start_d;
  logic                      res_valid_q, res_valid_d;
  logic [3:0]                res_class_q, res_class_d;
  logic                      res_err_q, res_err_d;

  assign in_ready  = (state_q == S_FILL);
  assign logits_o  = logits_q;
  assign am_rst_n  = am_rst_n_q;
  assign am_start  = am_start_q;
  assign res_valid = res_valid_q;
  assign res_class = res_class_q;
  assign res_err   = res_err_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rearm_d     = rearm_q;
    wait_d      = wait_q;
    logits_d    = logits_q;
    am_rst_n_d  = am_rst_n_q;
    am_start_d  = am_start_q;
    res_valid_d = res_valid_q;
    res_class_d = res_class_q;
    res_err_d   = res_err_q;

    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          logits_d[int'(idx_q)*WIDTH +: WIDTH] = in_data;
          if (idx_q == IW'(N_LOGITS - 1)) begin
            // A full frame always runs the engine; a missing in_last is only flagged.
            state_d    = S_REARM;
            rearm_d    = RCW'(REARM_CYC);
            am_rst_n_d = 1'b0;
            res_err_d  = ~in_last;
          end else if (in_last) begin
            state_d     = S_RESULT;
            res_class_d = 4'hF;
            res_err_d   = 1'b1;
            res_valid_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      S_REARM: begin
        am_rst_n_d = 1'b0;
        if (rearm_q <= RCW'(1)) begin
          state_d    = S_START;
          am_rst_n_d = 1'b1;
          am_start_d = 1'b1;
        end else begin
          rearm_d = rearm_q - RCW'(1);
        end
      end

      S_START: begin
        state_d    = S_WAIT;
        am_start_d = 1'b0;
        wait_d     = WCW'(ARGMAX_LAT - 1);
      end

      S_WAIT: begin
        if (wait_q == '0) begin
          state_d     = S_RESULT;
          res_class_d = am_count;
          res_valid_d = 1'b1;
          if (am_count == 4'hF) res_err_d = 1'b1;
        end else begin
          wait_d = wait_q - WCW'(1);
        end
      end

      S_RESULT: begin
        if (res_ready) begin
          state_d     = S_FILL;
          res_valid_d = 1'b0;
          res_err_d   = 1'b0;
          idx_d       = '0;
        end
      end

      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FILL;
      idx_q       <= '0;
      rearm_q     <= '0;
      wait_q      <= '0;
      logits_q    <= '0;
      am_rst_n_q  <= 1'b0;
      am_start_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_class_q <= 4'hF;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rearm_q     <= rearm_d;
      wait_q      <= wait_d;
      logits_q    <= logits_d;
      am_rst_n_q  <= am_rst_n_d;
      am_start_q  <= am_start_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      res_err_q   <= res_err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_logit_frame_feeder.sv
// ---------------------------------------------------------------------------
// tb_logit_frame_feeder : scoreboard bench with a behavioural argmax engine
//                         model and real-valued fp16 reference.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_logit_frame_feeder;

  localparam int N   = 10;
  localparam int LAT = 28;
  localparam int RC  = 2;

  typedef logic [15:0] frame_t [10];
  typedef struct packed {
    logic [3:0] cls;
    logic       err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid, in_ready, in_last;
  logic [15:0]  in_data;
  logic [159:0] logits_o;
  logic         am_rst_n, am_start;
  logic [3:0]   am_count = 4'hF;
  logic         res_valid, res_ready, res_err;
  logic [3:0]   res_class;

  int   n_checks = 0, n_fail = 0;
  int   n_starts = 0, exp_starts = 0;
  exp_t sb[$];
  bit   eng_stall = 1'b0;
  bit   rr_rand = 1'b0;

  logit_frame_feeder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .logits_o(logits_o), .am_rst_n(am_rst_n), .am_start(am_start), .am_count(am_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class), .res_err(res_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic real pow2(input int n);
    real p = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) p = p * 2.0;
    else        for (int i = 0; i < -n; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    real m = real'(int'(h[9:0])) / 1024.0;
    real r = (e == 0) ? m * pow2(-14) : (1.0 + m) * pow2(e - 15);
    return h[15] ? -r : r;
  endfunction

  // Lowest index wins on equal values.
  function automatic int argmax(input frame_t v);
    int b = 0;
    for (int k = 1; k < N; k++) if (h2r(v[k]) > h2r(v[b])) b = k;
    return b;
  endfunction

  function automatic frame_t unpack_buf(input logic [159:0] f);
    frame_t v;
    for (int k = 0; k < N; k++) v[k] = f[16*k +: 16];
    return v;
  endfunction

  function automatic logic [15:0] rnd_h();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)), 10'($urandom_range(0, 1023))};
  endfunction

  function automatic frame_t rnd_frame();
    frame_t v;
    for (int k = 0; k < N; k++) v[k] = rnd_h();
    return v;
  endfunction

  // Engine model: index resolves 26 cycles after start; 4'hF while held or busy.
  logic       eng_busy = 1'b0;
  logic [4:0] eng_cnt  = '0;
  always @(posedge clk) begin
    if (!am_rst_n) begin
      am_count <= 4'hF;
      eng_busy <= 1'b0;
    end else if (am_start) begin
      am_count <= 4'hF;
      eng_cnt  <= 5'd26;
      eng_busy <= 1'b1;
    end else if (eng_busy) begin
      if (eng_cnt == 5'd1) begin
        eng_busy <= 1'b0;
        if (!eng_stall) am_count <= 4'(argmax(unpack_buf(logits_o)));
      end else begin
        eng_cnt <= eng_cnt - 5'd1;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rr_rand) res_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: result scoreboard, hold stability, start pulse shape, latency.
  initial begin
    bit         pend = 0, had_high = 0, prev_start = 0, prev_valid = 0, start_seen = 0;
    logic [3:0] pcls = '0;
    logic       perr = 0;
    int         low_run = 0, cyc = 0, t_start = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        pend = 0; had_high = 0; prev_start = 0; prev_valid = 0; start_seen = 0; low_run = 0;
      end else begin
        if (pend) begin
          chk("hold_valid", 160'(res_valid), 160'(1));
          chk("hold_class", 160'(res_class), 160'(pcls));
          chk("hold_err", 160'(res_err), 160'(perr));
        end
        if (res_valid && !prev_valid && start_seen) begin
          chk("latency", 160'(cyc - t_start), 160'(LAT + 1));
          start_seen = 0;
        end
        if (res_valid) chk("in_ready_in_result", 160'(in_ready), 160'(0));
        if (res_valid && res_ready) begin
          if (sb.size() == 0) chk("unexpected_result", 160'(res_valid), 160'(0));
          else begin
            e = sb.pop_front();
            chk("res_class", 160'(res_class), 160'(e.cls));
            chk("res_err", 160'(res_err), 160'(e.err));
          end
          pend = 0;
        end else if (res_valid) begin
          pend = 1; pcls = res_class; perr = res_err;
        end else begin
          pend = 0;
        end
        prev_valid = res_valid;
        if (am_start) begin
          n_starts++;
          t_start = cyc;
          start_seen = 1;
          chk("start_width", 160'(prev_start), 160'(0));
          chk("rst_n_at_start", 160'(am_rst_n), 160'(1));
          if (had_high) chk("rearm_low_cycles", 160'(low_run), 160'(RC));
        end
        prev_start = am_start;
        if (!am_rst_n) low_run++;
        else begin
          low_run = 0; had_high = 1;
        end
      end
    end
  end

  task automatic send_frame(input frame_t v, input int nbeats, input bit last_flag, input bit gaps);
    exp_t e;
    int   g, t;
    if (nbeats < N) begin
      e.cls = 4'hF; e.err = 1'b1;
    end else begin
      e.cls = eng_stall ? 4'hF : 4'(argmax(v));
      e.err = !last_flag || eng_stall;
      exp_starts++;
    end
    sb.push_back(e);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = v[b];
      in_last  = last_flag && (b == nbeats - 1);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin t++; @(negedge clk); end
      if (!in_ready) begin
        chk("beat_accept_timeout", 160'(in_ready), 160'(1));
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    if (sb.size() != 0) chk("drain_timeout", 160'(sb.size()), 160'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    frame_t fa, fb, fc, fr;
    logic [159:0] saved;
    int s0, t, nb, r;
    bit lf;

    in_valid = 0; in_data = '0; in_last = 0; res_ready = 1;
    fa = '{16'h3C00, 16'h4000, 16'h4200, 16'hBC00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int k = 0; k < N; k++) begin fb[k] = 16'h3C00; fc[k] = 16'h3C00; end
    fb[9] = 16'h4400;
    fc[0] = 16'h4400;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 160'(in_ready), 160'(1));
    chk("rst_am_rst_n", 160'(am_rst_n), 160'(0));
    chk("rst_am_start", 160'(am_start), 160'(0));
    chk("rst_res_valid", 160'(res_valid), 160'(0));
    chk("rst_res_class", 160'(res_class), 160'(4'hF));
    chk("rst_res_err", 160'(res_err), 160'(0));
    chk("rst_logits", logits_o, 160'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    send_frame(fa, 10, 1'b1, 1'b0);
    drain();

    send_frame(fb, 10, 1'b1, 1'b0);
    send_frame(fc, 10, 1'b1, 1'b0);
    drain();

    s0 = n_starts;
    send_frame(rnd_frame(), 5, 1'b1, 1'b0);
    drain();
    chk("abort_no_start", 160'(n_starts), 160'(s0));
    send_frame(rnd_frame(), 10, 1'b1, 1'b0);
    drain();

    send_frame(rnd_frame(), 10, 1'b0, 1'b0);
    drain();

    eng_stall = 1'b1;
    send_frame(rnd_frame(), 10, 1'b1, 1'b0);
    drain();
    eng_stall = 1'b0;

    // Result held back for 20 cycles while beats are offered.
    res_ready = 1'b0;
    send_frame(fa, 10, 1'b1, 1'b0);
    t = 0;
    while (!res_valid && t < 200) begin @(negedge clk); t++; end
    chk("hold_res_valid_seen", 160'(res_valid), 160'(1));
    saved = logits_o;
    repeat (20) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = rnd_h();
      in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold_in_ready", 160'(in_ready), 160'(0));
      chk("hold_buffer", logits_o, saved);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b1;
    drain();

    rr_rand = 1'b1;
    repeat (20) begin
      r = $urandom_range(0, 9);
      fr = rnd_frame();
      if (r == 0) begin nb = $urandom_range(1, 9); lf = 1'b1; end
      else if (r == 1) begin nb = 10; lf = 1'b0; end
      else begin nb = 10; lf = 1'b1; end
      send_frame(fr, nb, lf, 1'b1);
    end
    drain();
    rr_rand = 1'b0;
    @(posedge clk);
    #1;
    res_ready = 1'b1;

    // Reset while the engine is running.
    send_frame(fa, 10, 1'b1, 1'b0);
    t = 0;
    @(negedge clk);
    while (!am_start && t < 100) begin @(negedge clk); t++; end
    chk("start_before_reset", 160'(am_start), 160'(1));
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_res_valid", 160'(res_valid), 160'(0));
    chk("mid_rst_am_rst_n", 160'(am_rst_n), 160'(0));
    chk("mid_rst_logits", logits_o, 160'(0));
    chk("mid_rst_in_ready", 160'(in_ready), 160'(1));
    sb.delete();
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_frame(fb, 10, 1'b1, 1'b0);
    drain();

    repeat (5) @(posedge clk);
    chk("start_count", 160'(n_starts), 160'(exp_starts));
    chk("sb_empty", 160'(sb.size()), 160'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/logit_frame_feeder.md
Name: logit_frame_feeder

Overview:
Front-end feeder for the 10-way fp16 argmax engine at the classifier output. It collects a serial stream of fp16 logits over a valid/ready handshake into a 10-entry frame buffer and drives the engine's parallel float inputs. It re-arms the engine through its reset, issues start, and waits the engine's fixed latency before sampling the winning index. The index is returned on a valid/ready result port.

Parameters:
N_LOGITS, 10, logits per frame; fixed to engine width, not to be overridden
WIDTH, 16, bits per logit (fp16)
ARGMAX_LAT, 28, cycles from engine start-accept to stable index; engine needs 26, 2 margin
REARM_CYC, 2, cycles am_rst_n is held low before each start

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  logit beat valid
in_ready  out  1  feeder accepts beat
in_data  in  16  fp16 logit
in_last  in  1  final beat of frame
logits_o  out  160  frame buffer; logit k at bits [16k+15:16k], wired to engine float0..float9
am_rst_n  out  1  engine reset, active-low
am_start  out  1  engine start
am_count  in  4  engine winning index; 4'hF = not yet resolved
res_valid  out  1  result valid
res_ready  in  1  result consumed
res_class  out  4  winning index 0..9, or 4'hF on aborted frame
res_err  out  1  frame framing/engine error

Behaviour:
- Reset is asynchronous, active-low, clock is clk. Reset values:
  - state FILL, beat idx 0, logits_o all 0.
  - am_rst_n 0 (engine held), am_start 0.
  - res_valid 0, res_class 4'hF, res_err 0.
- in_ready = (state==FILL), combinational from state. A beat transfers on in_valid&&in_ready.
- FSM, all outputs registered except in_ready:
  - FILL: each transfer writes in_data to slot idx, then idx++.
    - in_last with idx<9: abort. Set res_class=4'hF, res_err=1, go RESULT. The engine is not run. Slots keep stale data.
    - Transfer at idx==9: go REARM regardless of in_last. res_err=1 if in_last was 0 on that beat.
  - REARM: am_rst_n=0 for REARM_CYC cycles (down-counter), then go START.
  - START: am_rst_n=1, am_start=1 for exactly 1 cycle, then go WAIT. The engine samples start on this edge and leaves its idle state.
  - WAIT: am_start=0. Count ARGMAX_LAT cycles. On the last cycle, register res_class<=am_count. If am_count==4'hF, also set res_err. Go RESULT.
  - RESULT: res_valid=1, held stable with res_class/res_err until res_ready. On the res_valid&&res_ready edge: res_valid<=0, res_err<=0, idx<=0, go FILL. res_ready while res_valid=0 is ignored.
- am_rst_n stays 1 from START until the next REARM. The engine holds its final index between frames.
- Frame buffer slots change only in FILL. logits_o is stable throughout REARM/START/WAIT.
- Back-to-back frames: the first beat of the next frame can be accepted the cycle after the result handshake. Minimum frame period = 10 + REARM_CYC + 1 + ARGMAX_LAT + 1 cycles.
- Reset mid-operation (any state) returns to the reset values immediately. A partial frame is discarded, and am_rst_n going to 0 also resets the engine.
- Counter widths: idx 4 bits, REARM counter ceil(log2(REARM_CYC+1)) bits, WAIT counter 6 bits. None wrap in normal operation.

Test Plan:
- Frame 0x3C00,0x4000,0x4200,0xBC00,0,0,0,0,0,0 with in_last on beat 9, res_ready=1 -> am_start one pulse, res_valid after ARGMAX_LAT, res_class=2, res_err=0.
- Max at last slot (beats 0..8 = 0x3C00, beat 9 = 0x4400) -> res_class=9. Then an immediate second frame with max 0x4400 at slot 0 -> am_rst_n low 2 cycles before its start, res_class=0.
- in_last asserted on beat 4 -> no am_start pulse, res_valid with res_class=4'hF, res_err=1. The next full frame is accepted from idx 0.
- Full 10 beats with in_last=0 on beat 9 -> engine runs, correct res_class, res_err=1.
- Hold res_ready=0 for 20 cycles in RESULT -> in_ready=0, res_valid/res_class stable. Beats driven meanwhile are not accepted.
- Assert rst low during WAIT -> res_valid=0, am_rst_n=0, logits_o=0. After release, a fresh frame completes correctly.
